// File: rtl/ddr_sched_pkg.sv
// Shared types and DDR command encodings for the bank command sequencer.
// Request fields are sized to the widest row/column this controller family supports.
package ddr_sched_pkg;

    localparam int unsigned BANK_SZ        = 3;
    localparam int unsigned NUM_BANKS      = 1 << BANK_SZ;
    localparam int unsigned DEC_DDR_CMD_SZ = 4;
    localparam int unsigned DDR_ROW_SZ     = 14;
    localparam int unsigned DDR_COL_SZ     = 10;

    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_NOP     = 4'hF;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_REF     = 4'h1;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_PRE     = 4'h2;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_ACT     = 4'h3;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_WRITE   = 4'h4;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_READ    = 4'h5;
    localparam logic [DEC_DDR_CMD_SZ-1:0] DDR_PRE_ALL = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_RW,
        S_PREA,
        S_REF
    } seq_state_t;

    typedef struct packed {
        logic                  write;
        logic [BANK_SZ-1:0]    bank;
        logic [DDR_ROW_SZ-1:0] row;
        logic [DDR_COL_SZ-1:0] col;
    } ddr_req_t;

    function automatic logic [DEC_DDR_CMD_SZ-1:0] rw_cmd(input logic write);
        return write ? DDR_WRITE : DDR_READ;
    endfunction

endpackage

// File: rtl/refresh_interval_timer.sv
// Periodic refresh request generator: a free-running down-counter that raises ref_pending
// every REFI_CYCLES clocks and flags a sticky overrun if the previous refresh is still owed.
module refresh_interval_timer #(
    parameter int unsigned REFI_CYCLES = 1560
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic ref_pending,
    output logic ref_overrun
);

    localparam int unsigned CNT_W = (REFI_CYCLES > 2) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFI_CYCLES - 1);

    if (REFI_CYCLES < 2) begin : g_refi_check
        $error("REFI_CYCLES must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    // An expiry while a refresh is still owed keeps exactly one pending and marks the overrun.
    always_comb begin
        expire    = (cnt_q == '0);
        cnt_d     = expire ? RELOAD : cnt_q - 1'b1;
        pending_d = (pending_q & ~clear) | expire;
        overrun_d = overrun_q | (expire & pending_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign ref_pending = pending_q;
    assign ref_overrun = overrun_q;

endmodule

// File: rtl/bank_cmd_sequencer.sv
// Open-page DDR3 command sequencer: expands one request at a time into PRE/ACT/RD/WR,
// gated by the timing checker, and interleaves PRE_ALL/REF when a refresh falls due.
module bank_cmd_sequencer
    import ddr_sched_pkg::*;
#(
    parameter int unsigned ROW_SZ      = DDR_ROW_SZ,
    parameter int unsigned COL_SZ      = DDR_COL_SZ,
    parameter int unsigned REFI_CYCLES = 1560
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [BANK_SZ-1:0]        req_bank,
    input  logic [ROW_SZ-1:0]         req_row,
    input  logic [COL_SZ-1:0]         req_col,
    output logic                      rsp_done,
    output logic [DEC_DDR_CMD_SZ-1:0] tmr_cmd,
    output logic [BANK_SZ-1:0]        tmr_bank,
    input  logic                      tmr_valid,
    output logic                      tmr_issue,
    input  logic [1:0]                tmr_offset,
    output logic                      cmd_valid,
    output logic [DEC_DDR_CMD_SZ-1:0] cmd_code,
    output logic [BANK_SZ-1:0]        cmd_bank,
    output logic [ROW_SZ-1:0]         cmd_addr,
    output logic [1:0]                cmd_slot,
    output logic                      ref_overrun
);

    if (COL_SZ > ROW_SZ) begin : g_col_check
        $error("COL_SZ must not exceed ROW_SZ");
    end
    if (ROW_SZ > DDR_ROW_SZ || COL_SZ > DDR_COL_SZ) begin : g_width_check
        $error("ROW_SZ/COL_SZ exceed the request record widths");
    end

    seq_state_t                          state_q, state_d;
    ddr_req_t                            req_q, req_d;
    logic [NUM_BANKS-1:0]                bank_open_q, bank_open_d;
    logic [NUM_BANKS-1:0][ROW_SZ-1:0]    open_row_q, open_row_d;
    logic                                active_q;
    logic                                ref_pending;
    logic                                ref_clear;
    logic                                accept;
    logic [ROW_SZ-1:0]                   addr_sel;

    refresh_interval_timer #(
        .REFI_CYCLES (REFI_CYCLES)
    ) u_refresh_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (ref_clear),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            bank_open_q <= '0;
            open_row_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            active_q    <= 1'b1;
        end
    end

    // Refresh wins over a same-cycle request; the request is classified against the bank table.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        ref_clear   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ref_pending) begin
                    state_d = (|bank_open_q) ? S_PREA : S_REF;
                end else if (accept) begin
                    req_d.write = req_write;
                    req_d.bank  = req_bank;
                    req_d.row   = DDR_ROW_SZ'(req_row);
                    req_d.col   = DDR_COL_SZ'(req_col);
                    if (!bank_open_q[req_bank]) begin
                        state_d = S_ACT;
                    end else if (open_row_q[req_bank] == req_row) begin
                        state_d = S_RW;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (tmr_valid) begin
                    bank_open_d[req_q.bank] = 1'b0;
                    state_d                 = S_ACT;
                end
            end
            S_ACT: begin
                if (tmr_valid) begin
                    bank_open_d[req_q.bank] = 1'b1;
                    open_row_d[req_q.bank]  = req_q.row[ROW_SZ-1:0];
                    state_d                 = S_RW;
                end
            end
            S_RW: begin
                if (tmr_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_PREA: begin
                if (tmr_valid) begin
                    bank_open_d = '0;
                    state_d     = S_REF;
                end
            end
            S_REF: begin
                if (tmr_valid) begin
                    ref_clear = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = active_q && (state_q == S_IDLE) && !ref_pending;
        tmr_cmd   = DDR_NOP;
        tmr_bank  = '0;
        addr_sel  = '0;
        unique case (state_q)
            S_IDLE: tmr_cmd = DDR_NOP;
            S_PRE: begin
                tmr_cmd  = DDR_PRE;
                tmr_bank = req_q.bank;
            end
            S_ACT: begin
                tmr_cmd  = DDR_ACT;
                tmr_bank = req_q.bank;
                addr_sel = req_q.row[ROW_SZ-1:0];
            end
            S_RW: begin
                tmr_cmd  = rw_cmd(req_q.write);
                tmr_bank = req_q.bank;
                addr_sel = ROW_SZ'(req_q.col[COL_SZ-1:0]);
            end
            S_PREA: tmr_cmd = DDR_PRE_ALL;
            S_REF:  tmr_cmd = DDR_REF;
            default: tmr_cmd = DDR_NOP;
        endcase
        cmd_valid = (state_q != S_IDLE) && tmr_valid;
        tmr_issue = cmd_valid;
        rsp_done  = cmd_valid && (state_q == S_RW);
        cmd_code  = cmd_valid ? tmr_cmd : '0;
        cmd_bank  = cmd_valid ? tmr_bank : '0;
        cmd_addr  = cmd_valid ? addr_sel : '0;
        cmd_slot  = cmd_valid ? tmr_offset : 2'b00;
    end

endmodule
